rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter with grant hold and forced preemption. It sits directly upstream of the team's 2-to-4 decoder. `gnt_idx` drives the decoder's 2-bit select, and the decoder's one-hot outputs become the per-requester grant lines. When `gnt_valid` is low, downstream logic gates the decoder outputs off.

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_arbiter4.sv | 97 +++++++++
 tb/tb_rr_arbiter4.sv | 124 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM state encoding for the four-way round-robin arbiter.
package arb_pkg;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit after last_idx, wrapping,
// so the previous holder is searched last.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] cand;
  logic             found;

  assign any_req = |req;

  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    // Offset NREQ truncates to zero, so last_idx itself is the final candidate.
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_idx + IDX_W'(k);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold limit and timeout preemption.
// gnt_idx feeds a downstream 2-to-4 decoder; gnt_valid gates its outputs.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             preempt
);

  localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_MAX - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
  logic [IDX_W-1:0] last_idx_reg, last_idx_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic             final_reg, final_next;

  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             holder_req;
  logic             grant_end;

  // During a grant the holder becomes the new last_idx at grant end, so the
  // same-cycle pick must already search from the holder.
  assign pick_last  = (state_reg == GRANT) ? gnt_idx_reg : last_idx_reg;
  assign holder_req = req[gnt_idx_reg];
  assign grant_end  = done || !holder_req || (hold_cnt_reg == LAST_CNT);

  rr_pick4 u_pick (
    .req      (req),
    .last_idx (pick_last),
    .win_idx  (win_idx),
    .any_req  (any_req)
  );

  always_comb begin
    state_next    = state_reg;
    gnt_idx_next  = gnt_idx_reg;
    last_idx_next = last_idx_reg;
    hold_cnt_next = hold_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = GRANT;
          gnt_idx_next  = win_idx;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          last_idx_next = gnt_idx_reg;
          hold_cnt_next = '0;
          if (any_req) begin
            gnt_idx_next = win_idx;
          end else begin
            state_next = IDLE;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    final_next = (state_next == GRANT) && (hold_cnt_next == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_idx_reg  <= '0;
      last_idx_reg <= IDX_W'(NREQ - 1);
      hold_cnt_reg <= '0;
      final_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_idx_reg  <= gnt_idx_next;
      last_idx_reg <= last_idx_next;
      hold_cnt_reg <= hold_cnt_next;
      final_reg    <= final_next;
    end
  end

  assign gnt_valid = (state_reg == GRANT);
  assign gnt_idx   = gnt_idx_reg;
  // The registered timeout flag is qualified by same-cycle done/drop, which win.
  assign preempt   = final_reg && !done && holder_req;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (HOLD_MAX=4): reset, rotation, single requester,
// timeout, simultaneous end, holder drop and mid-grant asynchronous reset.
module tb_rr_arbiter4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       preempt;

  int passed = 0;
  int total  = 0;

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs are applied first; #1 lets preempt settle before sampling.
  task automatic chk(input string tag, input logic ev, input logic [1:0] ei, input logic ep,
                     input logic check_idx);
    #1;
    total++;
    assert (gnt_valid === ev) passed++;
    else $error("FAIL %s gnt_valid observed %0b expected %0b", tag, gnt_valid, ev);
    if (check_idx) begin
      total++;
      assert (gnt_idx === ei) passed++;
      else $error("FAIL %s gnt_idx observed %0d expected %0d", tag, gnt_idx, ei);
    end
    total++;
    assert (preempt === ep) passed++;
    else $error("FAIL %s preempt observed %0b expected %0b", tag, preempt, ep);
    $display("t=%0t %s req=%b done=%b -> valid=%b idx=%0d preempt=%b",
             $time, tag, req, done, gnt_valid, gnt_idx, preempt);
  endtask

  initial begin
    // Reset with all requesting.
    rst_n = 1'b0; req = 4'b1111; done = 1'b0;
    cyc(); cyc();
    chk("reset", 1'b0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Full rotation, done on each grant's second cycle.
    for (int g = 0; g < 5; g++) begin
      cyc();
      done = 1'b0;
      chk($sformatf("rot%0d_c0", g), 1'b1, 2'(g % 4), 1'b0, 1'b1);
      cyc();
      if (g < 4) done = 1'b1;
      else req = 4'b0000;
      chk($sformatf("rot%0d_c1", g), 1'b1, 2'(g % 4), 1'b0, 1'b1);
    end
    cyc();
    done = 1'b0;
    chk("rot_drop_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Single requester 2; it drops along with done on the third grant cycle.
    req = 4'b0100;
    chk("single_t", 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(); chk("single_t1", 1'b1, 2'd2, 1'b0, 1'b1);
    cyc(); chk("single_t2", 1'b1, 2'd2, 1'b0, 1'b1);
    cyc(); done = 1'b1; req = 4'b0000;
    chk("single_t3", 1'b1, 2'd2, 1'b0, 1'b1);
    cyc(); done = 1'b0;
    chk("single_t4", 1'b0, 2'd0, 1'b0, 1'b0);

    // Timeout: 0011 held, grants alternate 0,1 with preempt on each 4th cycle.
    req = 4'b0011;
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < 4; c++) begin
        cyc();
        chk($sformatf("to_g%0d_c%0d", g, c), 1'b1, 2'(g % 2), (c == 3), 1'b1);
      end
    end

    // Simultaneous end: done on the 4th cycle of the third grant suppresses preempt.
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (c == 3) done = 1'b1;
      chk($sformatf("sim_c%0d", c), 1'b1, 2'd0, 1'b0, 1'b1);
    end
    cyc(); done = 1'b0;
    chk("sim_next", 1'b1, 2'd1, 1'b0, 1'b1);

    // Holder 1 drops; 3 wins with no bubble, then drops to idle.
    cyc(); req = 4'b1000;
    chk("drop1", 1'b1, 2'd1, 1'b0, 1'b1);
    cyc(); chk("grant3", 1'b1, 2'd3, 1'b0, 1'b1);
    cyc(); req = 4'b0000;
    chk("drop3", 1'b1, 2'd3, 1'b0, 1'b1);
    cyc(); chk("drop3_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Mid-grant asynchronous reset.
    req = 4'b0100;
    cyc(); chk("pre_rst_grant", 1'b1, 2'd1 + 2'd1, 1'b0, 1'b1);
    #2 rst_n = 1'b0; req = 4'b1111;
    chk("async_rst", 1'b0, 2'd0, 1'b0, 1'b1);
    cyc();
    chk("rst_held", 1'b0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(); chk("restart0", 1'b1, 2'd0, 1'b0, 1'b1);
    done = 1'b1;
    cyc(); done = 1'b0;
    chk("restart1", 1'b1, 2'd1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
